// File: rtl/fifo_umbral_pkg.sv
//------------------------------------------------------------------------------
// fifo_umbral_pkg : shared widths, default thresholds and channel count for
//                   the transaction-layer FIFOs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_umbral_pkg;
  localparam int FIFO_DATA_W     = 10;
  localparam int FIFO_ADDR_W     = 3;
  localparam int UMBRAL_ALTO_DEF = 6;
  localparam int UMBRAL_BAJO_DEF = 2;
  localparam int NUM_FIFOS       = 10;
endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
//------------------------------------------------------------------------------
// fifo_mem : 2**ADDR_W x DATA_W register file, one synchronous write port and
//            one registered read port. Storage itself is never reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_mem
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is cleared; it holds its value between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_umbral.sv
//------------------------------------------------------------------------------
// fifo_umbral : single-clock FIFO with full/empty and threshold-based
//               almost_full/almost_empty flags. Macro FIFO_ERR_EN enables the
//               sticky overflow/underflow flag on err.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic [ADDR_W-1:0] umbral_alto,
  input  logic [ADDR_W-1:0] umbral_bajo,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int            c_DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0]   c_FULL_CNT  = c_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   c_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_full   = (r_count == c_FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Acceptance is judged on the pre-edge count; reset masks both requests.
  assign w_wr_acc = reset && wr_en && !w_full;
  assign w_rd_acc = reset && rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

`ifdef FIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if ((wr_en && w_full) || (rd_en && w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign valid_out    = r_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= {1'b0, umbral_alto});
  assign almost_empty = (r_count <= {1'b0, umbral_bajo});

endmodule

`default_nettype wire

// File: tb/tb_fifo_umbral.sv
//------------------------------------------------------------------------------
// tb_fifo_umbral : directed plus randomized stimulus for fifo_umbral, checked
//                  against a queue-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_umbral;
  import fifo_umbral_pkg::*;

  localparam int c_DW = FIFO_DATA_W;
  localparam int c_AW = FIFO_ADDR_W;
  localparam int c_DEPTH = 2**c_AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [c_DW-1:0] data_in;
  logic            rd_en;
  logic [c_DW-1:0] data_out;
  logic            valid_out;
  logic [c_AW-1:0] umbral_alto;
  logic [c_AW-1:0] umbral_bajo;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [c_AW:0]   count;
  logic            err;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int m_q[$];
  int m_data  = 0;
  int m_valid = 0;
  int m_err   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  acc_rd;
    bit  acc_wr;
    if (!reset) begin
      m_q.delete();
      m_data  = 0;
      m_valid = 0;
      m_err   = 0;
    end else begin
      sz     = m_q.size();
      acc_rd = rd_en && (sz != 0);
      acc_wr = wr_en && (sz != c_DEPTH);
`ifdef FIFO_ERR_EN
      if ((wr_en && sz == c_DEPTH) || (rd_en && sz == 0)) m_err = 1;
`endif
      if (acc_rd) m_data = m_q.pop_front();
      m_valid = acc_rd ? 1 : 0;
      if (acc_wr) m_q.push_back(int'(data_in));
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    check("count",        int'(count),        sz);
    check("empty",        int'(empty),        (sz == 0) ? 1 : 0);
    check("full",         int'(full),         (sz == c_DEPTH) ? 1 : 0);
    check("almost_full",  int'(almost_full),  (sz >= int'(umbral_alto)) ? 1 : 0);
    check("almost_empty", int'(almost_empty), (sz <= int'(umbral_bajo)) ? 1 : 0);
    check("valid_out",    int'(valid_out),    m_valid);
    check("data_out",     int'(data_out),     m_data);
    check("err",          int'(err),          m_err);
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic cyc(input logic rst_n, input logic w, input int d, input logic r);
    reset   = rst_n;
    wr_en   = w;
    data_in = d[c_DW-1:0];
    rd_en   = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset       = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    data_in     = '0;
    umbral_alto = c_AW'(UMBRAL_ALTO_DEF);
    umbral_bajo = c_AW'(UMBRAL_BAJO_DEF);

    cyc(1'b0, 1'b0, 0, 1'b0);
    check("rst_empty", int'(empty), 1);
    check("rst_aempty", int'(almost_empty), 1);
    cyc(1'b1, 1'b0, 0, 1'b0);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b1, i, 1'b0);
    cyc(1'b1, 1'b1, 'h3FF, 1'b0);
    check("full_hold", int'(count), 8);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 0, 1'b1);
      check("rd_seq", int'(data_out), i);
    end
    cyc(1'b1, 1'b0, 0, 1'b1);
    check("rd_empty_valid", int'(valid_out), 0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 'h10 + i, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 'h155, 1'b1);
    check("wrap_count", int'(count), 4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0, 1'b1);

    cyc(1'b1, 1'b1, 'h2AA, 1'b1);
    check("sim_empty_cnt", int'(count), 1);
    cyc(1'b1, 1'b0, 0, 1'b1);
    check("sim_empty_rd", int'(data_out), 'h2AA);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 'h40 + i, 1'b0);
    check("af_pre", int'(almost_full), 0);
    umbral_alto = 3'd4;
    #1;
    check("af_same_cycle", int'(almost_full), 1);
    cyc(1'b0, 1'b1, 'h77, 1'b0);
    check("rst_mid_cnt", int'(count), 0);
    cyc(1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_alto = c_AW'($urandom_range(0, c_DEPTH - 1));
        umbral_bajo = c_AW'($urandom_range(0, c_DEPTH - 1));
      end
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 99) < ((i / 100) % 2 ? 40 : 65)),
          int'($urandom_range(0, 1023)),
          ($urandom_range(0, 99) < ((i / 100) % 2 ? 65 : 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Synchronous single-clock FIFO for the transaction layer; one instance per channel.
- Its `empty` output feeds one bit of the controller's 10-bit FIFO_empty vector.
- Its `umbral_alto`/`umbral_bajo` inputs come from the controller's interno_alto/interno_bajo outputs.
- Produces full/empty plus threshold-based almost_full/almost_empty flags, which upstream and downstream use for flow control (pause/resume).

Parameters:
- DATA_W, 10, width of each stored word.
- ADDR_W, 3, pointer width; depth = 2**ADDR_W = 8 entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low.
- wr_en  input  1  write request.
- data_in  input  DATA_W  write data.
- rd_en  input  1  read request.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  high the cycle after an accepted read.
- umbral_alto  input  ADDR_W  almost-full threshold.
- umbral_bajo  input  ADDR_W  almost-empty threshold.
- full  output  1  count == 2**ADDR_W.
- empty  output  1  count == 0.
- almost_full  output  1  count >= umbral_alto.
- almost_empty  output  1  count <= umbral_bajo.
- count  output  ADDR_W+1  current occupancy, 0..8.
- err  output  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. While reset==0 at a rising edge:
  - wr_ptr = rd_ptr = 0, count = 0.
  - data_out = 0, valid_out = 0, err = 0.
  - Memory contents are not cleared.
- Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0 (the latter for any umbral_alto > 0).
- Write accepted when wr_en && !full: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping 7->0.
- Read accepted when rd_en && !empty:
  - data_out <= mem[rd_ptr]; rd_ptr increments with wrap.
  - valid_out = 1 in the following cycle; 1-cycle read latency.
- No accepted read: data_out holds its last value and valid_out = 0 next cycle.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Both accepted, or neither: unchanged.
- Full/empty gating uses the pre-edge count:
  - Write while full is dropped, even if a read is accepted the same cycle.
  - Read while empty is dropped, even if a write is accepted the same cycle.
- Flags are combinational from the registered count; no extra latency:
  - full = (count == 8), empty = (count == 0).
  - almost_full = (count >= {0, umbral_alto}) and almost_empty = (count <= {0, umbral_bajo}), zero-extended compare.
- Threshold edge cases:
  - Thresholds are sampled continuously; a change takes effect the same cycle.
  - umbral_alto == 0 forces almost_full = 1.
  - umbral_bajo >= count holds almost_empty = 1.
  - No legality check on umbral_bajo >= umbral_alto; both flags may be high together.
- Wrap-around: pointers roll naturally and count disambiguates full vs empty. 8 writes then 8 reads returns both pointers to 0 with empty=1.
- Reset mid-operation: all queued data is discarded (count=0) at the reset edge. A wr_en/rd_en in the same cycle is ignored.

Optional Feature:
- Macro: FIFO_ERR_EN.
- Defined: err is set on a dropped write (wr_en && full) or a dropped read (rd_en && empty). It is sticky and cleared only by reset.
- Undefined: err is tied to 0 and no error logic is generated. The port list is identical in both builds.

Decomposition:
- Shared package holds:
  - FIFO_DATA_W = 10, FIFO_ADDR_W = 3.
  - Default thresholds UMBRAL_ALTO_DEF = 6 and UMBRAL_BAJO_DEF = 2, matching the controller's post-reset values.
  - Channel count NUM_FIFOS = 10.
- One natural sub-module: fifo_mem.
  - 2**ADDR_W x DATA_W register file.
  - One synchronous write port, one registered read port, no reset on storage.
  - Pointer, count and flag logic stay in fifo_umbral.

Test Plan:
- Reset, thresholds 6/2, no requests -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, data_out=0, valid_out=0.
- Write 0x001..0x008 on 8 consecutive cycles:
  - almost_empty drops when count=3.
  - almost_full rises when count=6.
  - full=1 at count=8.
  - A 9th write of 0x3FF is dropped; count stays 8 and err=1 when FIFO_ERR_EN is defined.
- From full, 8 consecutive reads -> data_out = 0x001..0x008 each one cycle after its rd_en, valid_out high 8 cycles, then empty=1; a further read is dropped with valid_out=0.
- Count=4, simultaneous wr_en (0x155) and rd_en for 5 cycles -> count stays 4, FIFO order preserved across pointer wrap 7->0.
- Empty FIFO, wr_en and rd_en together with 0x2AA -> write accepted, read dropped, count=1, valid_out=0; next-cycle read returns 0x2AA.
- Count=5 with thresholds 6/2, then change umbral_alto to 4 -> almost_full=1 the same cycle. Pull reset low for one cycle -> count=0 and empty=1 at that edge; a concurrent write is ignored.
